// File: rtl/mac_tap_sequencer_if.sv
// mac_tap_sequencer_if: config, sample and operand signals of the FIR operand sequencer
interface mac_tap_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 8
);
  localparam int AW = $clog2(TAPS);
  logic              ena;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic              op_first;
  logic              op_last;
  logic              busy;
  modport master (
    output ena, cfg_we, cfg_addr, cfg_data, s_valid, s_data,
    input  s_ready, op_a, op_b, op_valid, op_first, op_last, busy
  );
  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_data, s_valid, s_data,
    output s_ready, op_a, op_b, op_valid, op_first, op_last, busy
  );
endinterface

// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: shifts samples into a TAPS-deep delay line and streams TAPS (sample, coef) pairs per sample
module mac_tap_sequencer #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 8
) (
  input logic                clk,
  input logic                rst_n,
  mac_tap_sequencer_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_coef [TAPS];
  logic [DATA_W-1:0] r_x    [TAPS];
  logic [AW-1:0]     r_t;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic              r_op_valid, r_op_first, r_op_last;
  logic              w_last_tap, w_ready, w_accept;
  logic [AW-1:0]     w_next_t;
  assign w_last_tap = r_t == AW'(TAPS - 1);
  assign w_next_t   = r_t + AW'(1);
  // rst_n gates ready so nothing is offered while reset is held
  assign w_ready    = rst_n && bus.ena && (r_state == IDLE || w_last_tap);
  assign w_accept   = w_ready && bus.s_valid;
  assign bus.s_ready  = w_ready;
  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.op_valid = r_op_valid;
  assign bus.op_first = r_op_first;
  assign bus.op_last  = r_op_last;
  assign bus.busy     = r_state == RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_t        <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
      r_op_first <= 1'b0;
      r_op_last  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_coef[k] <= '0;
        r_x[k]    <= '0;
      end
    end else if (bus.ena) begin
      if (bus.cfg_we) r_coef[bus.cfg_addr] <= bus.cfg_data;
      if (w_accept) begin
        r_x[0] <= bus.s_data;
        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
        r_state    <= RUN;
        r_t        <= '0;
        r_op_a     <= bus.s_data;
        r_op_b     <= r_coef[0];
        r_op_valid <= 1'b1;
        r_op_first <= 1'b1;
        r_op_last  <= 1'b0;
      end else if (r_state == RUN && !w_last_tap) begin
        r_t        <= w_next_t;
        r_op_a     <= r_x[w_next_t];
        r_op_b     <= r_coef[w_next_t];
        r_op_first <= 1'b0;
        r_op_last  <= w_next_t == AW'(TAPS - 1);
      end else begin
        // zero operands leave a free-running accumulator untouched
        r_state    <= IDLE;
        r_op_a     <= '0;
        r_op_b     <= '0;
        r_op_valid <= 1'b0;
        r_op_first <= 1'b0;
        r_op_last  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb_mac_tap_sequencer: directed vectors with hand-computed operand sequences
module tb_mac_tap_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_checks = 0;
  mac_tap_sequencer_if #(.DATA_W(8), .TAPS(8)) bus ();
  mac_tap_sequencer #(.DATA_W(8), .TAPS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_coef();
    for (int i = 0; i < 8; i++) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'(i);
      bus.cfg_data = 8'(i + 1);
      step();
    end
    bus.cfg_we = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.op_valid, 0);
    check({tag, "_a"}, bus.op_a, 0);
    check({tag, "_b"}, bus.op_b, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ready"}, bus.s_ready, 1);
  endtask
  task automatic frame(input logic [7:0] s, input int ea[8], input int eb[8],
                       input int stall_at, input int wr_at, input logic [7:0] wr_d);
    bus.s_valid = 1'b1;
    bus.s_data = s;
    step();
    bus.s_valid = 1'b0;
    for (int p = 0; p < 8; p++) begin
      check("op_a", bus.op_a, ea[p]);
      check("op_b", bus.op_b, eb[p]);
      check("op_valid", bus.op_valid, 1);
      check("op_first", bus.op_first, p == 0);
      check("op_last", bus.op_last, p == 7);
      check("busy", bus.busy, 1);
      check("s_ready", bus.s_ready, p == 7);
      if (p == stall_at) begin
        bus.ena = 1'b0;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'd200;
        repeat (3) begin
          step();
          check("stall_a", bus.op_a, ea[p]);
          check("stall_b", bus.op_b, eb[p]);
          check("stall_ready", bus.s_ready, 0);
        end
        bus.ena = 1'b1;
        bus.cfg_we = 1'b0;
      end
      if (p == wr_at) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'd4;
        bus.cfg_data = wr_d;
      end
      step();
      bus.cfg_we = 1'b0;
    end
    check_idle("end");
  endtask
  initial begin
    bus.ena = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) begin
      bus.ena = 1'($urandom);
      bus.cfg_we = 1'($urandom);
      bus.cfg_addr = 3'($urandom);
      bus.cfg_data = 8'($urandom);
      bus.s_valid = 1'($urandom);
      bus.s_data = 8'($urandom);
      step();
      check("rst_valid", bus.op_valid, 0);
      check("rst_a", bus.op_a, 0);
      check("rst_b", bus.op_b, 0);
      check("rst_first", bus.op_first, 0);
      check("rst_last", bus.op_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.s_ready, 0);
    end
    bus.ena = 1'b1;
    bus.cfg_we = 1'b0;
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_ready", bus.s_ready, 1);
    check("rel_busy", bus.busy, 0);
    load_coef();
    frame(8'd5, '{5, 0, 0, 0, 0, 0, 0, 0}, '{1, 2, 3, 4, 5, 6, 7, 8}, -1, -1, 8'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    load_coef();
    bus.s_valid = 1'b1;
    bus.s_data = 8'd1;
    step();
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 8; p++) begin
        check("b2b_a", bus.op_a, (p <= f) ? f + 1 - p : 0);
        check("b2b_b", bus.op_b, p + 1);
        check("b2b_valid", bus.op_valid, 1);
        check("b2b_first", bus.op_first, p == 0);
        check("b2b_ready", bus.s_ready, p == 7);
        if (p == 7) begin
          bus.s_data = 8'(f + 2);
          bus.s_valid = f < 2;
        end
        step();
      end
    check_idle("b2b_end");
    frame(8'd7, '{7, 3, 2, 1, 0, 0, 0, 0}, '{1, 2, 3, 4, 5, 6, 7, 8}, 3, -1, 8'd0);
    frame(8'd9, '{9, 7, 3, 2, 1, 0, 0, 0}, '{1, 2, 3, 4, 5, 6, 7, 8}, -1, 3, 8'd99);
    frame(8'd10, '{10, 9, 7, 3, 2, 1, 0, 0}, '{1, 2, 3, 4, 99, 6, 7, 8}, -1, -1, 8'd0);
    bus.s_valid = 1'b1;
    bus.s_data = 8'd11;
    step();
    bus.s_valid = 1'b0;
    repeat (5) step();
    check("mid_a", bus.op_a, 2);
    check("mid_b", bus.op_b, 6);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.op_valid, 0);
    check("mrst_a", bus.op_a, 0);
    check("mrst_b", bus.op_b, 0);
    check("mrst_last", bus.op_last, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_ready", bus.s_ready, 0);
    step();
    check("mrst_hold_last", bus.op_last, 0);
    rst_n = 1'b1;
    load_coef();
    frame(8'd12, '{12, 0, 0, 0, 0, 0, 0, 0}, '{1, 2, 3, 4, 5, 6, 7, 8}, -1, -1, 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mac_tap_sequencer.md
# mac_tap_sequencer

Operand sequencer that sits directly upstream of the MAC accumulator and turns it into an 8-tap FIR. Each accepted input sample is shifted into an 8-deep sample delay line. The block then emits exactly 8 (sample, coefficient) operand pairs on 8 consecutive enabled cycles, framed by first/last strobes. Coefficients live in a small register file loaded through a write port.

## Interface
- `DATA_W`, default 8: width of samples, coefficients and operands.
- `TAPS`, default 8: delay-line depth, coefficient count and pairs per frame. Must be a power of two and at least 2.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ena`, input, 1: global enable; when low, all state holds.
- `cfg_we`, input, 1: coefficient write strobe.
- `cfg_addr`, input, log2(TAPS): coefficient index.
- `cfg_data`, input, DATA_W: coefficient value, unsigned.
- `s_valid`, input, 1: input sample valid.
- `s_data`, input, DATA_W: input sample, unsigned.
- `s_ready`, output, 1: sample accepted at this edge if `s_valid` is also high; combinational.
- `op_a`, output, DATA_W: sample operand; registered.
- `op_b`, output, DATA_W: coefficient operand; registered.
- `op_valid`, output, 1: operand pair valid; registered.
- `op_first`, output, 1: pair is tap 0 of a frame; registered.
- `op_last`, output, 1: pair is tap TAPS-1 of a frame; registered.
- `busy`, output, 1: high while in RUN.

## Operation
- State: `coef[0..TAPS-1]`, delay line `x[0..TAPS-1]` (x[0] is the newest sample), FSM {IDLE, RUN}, tap counter `t`. `t` is the index of the pair currently on the outputs.
- Reset values: coef, x, `t` = 0; FSM = IDLE; `op_a`, `op_b`, `op_valid`, `op_first`, `op_last`, `busy` = 0.
- `s_ready = ena && (IDLE || (RUN && t == TAPS-1))`.
- Accept = `s_valid && s_ready`. At the accepting edge:
  - x shifts: x[k] <= x[k-1] and x[0] <= `s_data`. The oldest sample is discarded.
  - Outputs load pair 0: `op_a` = `s_data`, `op_b` = coef[0], `op_valid` = 1, `op_first` = 1, `op_last` = 0.
  - `t` <= 0; FSM <= RUN.
- RUN with `t` < TAPS-1, at each enabled edge:
  - `t` <= t+1.
  - `op_a` = x[t+1] from the post-shift line, `op_b` = coef[t+1].
  - `op_first` = 0; `op_last` = (t+1 == TAPS-1).
- RUN with `t` == TAPS-1 and no accept: FSM <= IDLE; `op_valid`, `op_first`, `op_last`, `op_a`, `op_b` <= 0. Zero operands keep a free-running downstream accumulator unaffected.
- RUN with `t` == TAPS-1 and accept: the next frame's pair 0 loads with no gap. Sustained throughput is 1 sample per TAPS cycles.
- IDLE without accept: outputs stay zero, `op_valid` = 0.
- Coefficient write: when `ena && cfg_we`, coef[`cfg_addr`] <= `cfg_data`. This is allowed in any state.
  - If the write targets the tap being loaded at the same edge, the old value is used.
  - The new value is visible from the next edge.
  - Mid-frame coefficient changes are not blocked; the software side owns coherence.
- `ena` low: no state, output, delay-line or coefficient changes; `s_ready` = 0; `cfg_we` is ignored.
- Asynchronous reset mid-frame: all state returns to reset values immediately. The partial frame is abandoned and no `op_last` is emitted.
- Arithmetic note: the downstream sum of TAPS products needs 2*DATA_W + log2(TAPS) bits, which is 19 bits at the defaults.

## Timing
- Sample-to-first-operand latency: 1 edge. The pair appears right after the accepting edge.
- Frame length: exactly TAPS enabled cycles, from `op_first` to `op_last` inclusive.
- Cycles with `ena` low stretch the frame but never drop or repeat a pair.
- `op_first` and `op_last` are never high together, because TAPS is at least 2.
- Frame alignment with the downstream 8-cycle accumulation window comes from a shared reset and the first sample arriving in the cycle after reset release. Back-to-back frames then stay aligned.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs -> all outputs 0, `s_ready` = 0. Release with `ena` = 1 -> `s_ready` = 1, `busy` = 0.
- Impulse response: load coef = 1..8, feed one sample 5 followed by idle -> `op_a` = 5,0,0,0,0,0,0,0 and `op_b` = 1..8. `op_first` on pair 1, `op_last` on pair 8, then `op_valid` = 0.
- Back-to-back: `s_valid` held with samples 1,2,3 -> frames start every 8 cycles with no gap. The third frame's `op_a` sequence is 3,2,1,0,0,0,0,0; `s_ready` is high only on the `t` = 7 cycles.
- Enable stall: drop `ena` for 3 cycles mid-frame at `t` = 3 -> outputs hold pair 3 for 3 extra cycles, then pairs 4..7 follow; no pair is skipped or duplicated.
- Coefficient write hazard: write coef[4] = 99 on the edge loading pair 4 -> pair 4 shows the old coef; the next frame's pair 4 shows 99.
- Reset mid-frame: assert `rst_n` at `t` = 5 -> outputs zero immediately. After release, the delay line is empty: the first new frame's `op_a` = s,0,0,0,0,0,0,0.
